// File: rtl/calc_keypad_entry.sv
// calc_keypad_entry: keypad-driven two-operand entry FSM feeding an ALU handshake (optional backspace via CALC_BACKSPACE_EN)
module calc_keypad_entry (
  input  logic        clk,
  input  logic        rst,
  input  logic        mode,
  input  logic [2:0]  pos_x,
  input  logic [1:0]  pos_y,
  input  logic        select,
  input  logic        exec_ready,
  output logic [15:0] input_screen,
  output logic [15:0] op1,
  output logic [15:0] op2,
  output logic [2:0]  op,
  output logic        exec_valid,
  output logic [1:0]  state
);
  typedef enum logic [1:0] {S_OP1 = 2'd0, S_OP2 = 2'd1, S_WAIT = 2'd2, S_RESULT = 2'd3} state_t;
  state_t      state_q, state_d;
  logic [15:0] screen_q, screen_d, op1_q, op1_d, op2_q, op2_d;
  logic [2:0]  op_q, op_d, count_q, count_d;
  logic        valid_q, valid_d, mode_q;
  logic [3:0]  digit;
  logic        in_entry, mode_chg, act, dig_ok, is_op, is_clr, is_enter;
`ifdef CALC_BACKSPACE_EN
  logic        is_bksp;
  assign is_bksp  = act && pos_x == 3'd5 && pos_y == 2'd1;
`endif
  assign digit    = {pos_y, pos_x[1:0]};
  assign in_entry = state_q == S_OP1 || state_q == S_OP2;
  assign mode_chg = mode != mode_q;
  // a select coinciding with a mode change in an entry state is dropped
  assign act      = select && !(in_entry && mode_chg);
  assign dig_ok   = act && !pos_x[2] && (mode || digit <= 4'd9);
  assign is_op    = act && pos_x == 3'd4;
  assign is_clr   = act && pos_x == 3'd5 && pos_y == 2'd0;
  assign is_enter = act && pos_x == 3'd5 && pos_y == 2'd2;
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_OP1;
      screen_q <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      op_q     <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      mode_q   <= mode;
    end else begin
      state_q  <= state_d;
      screen_q <= screen_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      op_q     <= op_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      mode_q   <= mode;
    end
  end
  // next-state logic; CLR wins everywhere except while waiting on the ALU
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_OP1:    state_d = is_op ? S_OP2 : S_OP1;
      S_OP2:    state_d = is_enter ? S_WAIT : S_OP2;
      S_WAIT:   state_d = exec_ready ? S_RESULT : S_WAIT;
      default:  state_d = dig_ok ? S_OP1 : S_RESULT;
    endcase
    if (is_clr && state_q != S_WAIT) state_d = S_OP1;
  end
  // datapath updates for entry, operand latching and clearing
  always_comb begin
    screen_d = screen_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    op_d     = op_q;
    count_d  = count_q;
    valid_d  = state_d == S_WAIT;
    if (in_entry && mode_chg) begin
      screen_d = '0;
      count_d  = '0;
    end else if (is_clr && state_q != S_WAIT) begin
      screen_d = '0;
      count_d  = '0;
      op1_d    = '0;
      op2_d    = '0;
      op_d     = '0;
    end else if (in_entry) begin
      if (dig_ok && count_q != 3'd4) begin
        screen_d = {screen_q[11:0], digit};
        count_d  = count_q + 3'd1;
      end else if (is_op) begin
        op_d = {1'b0, pos_y};
        if (state_q == S_OP1) begin
          op1_d    = screen_q;
          screen_d = '0;
          count_d  = '0;
        end
      end else if (is_enter && state_q == S_OP2) begin
        op2_d = screen_q;
      end
`ifdef CALC_BACKSPACE_EN
      else if (is_bksp && count_q != 3'd0) begin
        screen_d = {4'h0, screen_q[15:4]};
        count_d  = count_q - 3'd1;
      end
`endif
    end else if (state_q == S_RESULT && dig_ok) begin
      op1_d    = '0;
      op2_d    = '0;
      screen_d = {12'h000, digit};
      count_d  = 3'd1;
    end
  end
  assign input_screen = screen_q;
  assign op1          = op1_q;
  assign op2          = op2_q;
  assign op           = op_q;
  assign exec_valid   = valid_q;
  assign state        = state_q;
endmodule
